branch_resolve_ctrl: RTL
========================

# branch_resolve_ctrl

Sequences branch and jump resolution for the rv32imc execute stage. It accepts one control-transfer instruction at a time from EX and evaluates the branch condition. It computes the actual next PC and compares the outcome against the fetch-stage prediction. On a mispredict it issues a one-cycle redirect to fetch and holds a multi-cycle flush to the front-end stages, blocking new branches until the flush window ends.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush` stays high per mispredict; legal range 1..15.
- `CNT_W`, default 32: width of the performance counters.

- `clk` in 1: core clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX presents a branch, JAL or JALR.
- `ex_ready` out 1: block can accept; `ex_valid & ex_ready` = accept.
- `ex_pc` in 32: PC of the instruction.
- `ex_imm` in 32: sign-extended immediate.
- `ex_rs1`, `ex_rs2` in 32 each: forwarded operands.
- `ex_cmp_op` in 3: rv32imc_types funct3 encoding: beq=000, bne=001, blt=100, bge=101, bltu=110, bgeu=111.
- `ex_is_jal`, `ex_is_jalr` in 1 each: unconditional jump (mutually exclusive; both 0 = conditional branch).
- `ex_is_c` in 1: compressed instruction; fall-through is PC+2 instead of PC+4.
- `ex_pred_taken` in 1: prediction used by fetch.
- `ex_pred_target` in 32: predicted target used by fetch.
- `res_valid` out 1: one-cycle resolution pulse for predictor update.
- `res_taken` out 1: actual direction.
- `res_target` out 32: actual next PC.
- `redirect_valid` out 1: one-cycle fetch redirect.
- `redirect_pc` out 32: PC to fetch from.
- `flush` out 1: kill IF/ID contents.
- `perf_br_cnt`, `perf_mispred_cnt` out `CNT_W`: resolved-instruction and mispredict counts.

## Operation
- FSM states: IDLE, RESOLVE, FLUSH.
- **IDLE**
  - `ex_ready` = 1.
  - On accept, register all `ex_*` inputs and go to RESOLVE.
- **RESOLVE**
  - `ex_ready` = 0, `res_valid` = 1.
  - Taken:
    - Conditional branch: signed compare for blt/bge, unsigned for bltu/bgeu, equality for beq/bne.
    - Reserved `ex_cmp_op` 010/011 resolve not-taken.
    - JAL and JALR are always taken.
  - Target:
    - JALR: (rs1 + imm) & ~1.
    - Otherwise: pc + imm.
    - All adds are 32-bit modulo (wrap at 2^32).
  - `res_target` = target if taken, else pc+2 (`ex_is_c`) or pc+4.
  - Mispredict = (taken != pred_taken) | (taken & pred_taken & target != pred_target).
  - On mispredict:
    - `redirect_valid` = 1, `redirect_pc` = `res_target`, `flush` = 1.
    - Load the flush counter with FLUSH_CYCLES-1.
    - If FLUSH_CYCLES==1, go to IDLE; else go to FLUSH.
  - No mispredict: go to IDLE.
- **FLUSH**
  - `flush` = 1, `ex_ready` = 0.
  - Decrement the counter; go to IDLE when it reaches 0 after this cycle.
  - `ex_valid` is ignored; EX must hold it.
- Outputs are combinational from the registered request and state. `res_taken`, `res_target` and `redirect_pc` are valid only while their strobes are high and read 0 otherwise.

## Timing
- Accept at edge N; `res_valid`, `redirect_valid` and the first `flush` cycle are at cycle N+1.
- `flush` is high for exactly FLUSH_CYCLES consecutive cycles starting at N+1.
- Earliest next accept:
  - Correct prediction: edge N+2, giving one branch per 2 cycles.
  - Mispredict: edge N+1+FLUSH_CYCLES.
- `ex_ready` depends only on state, never on `ex_valid`.
- Reset, including mid-RESOLVE or mid-FLUSH:
  - State goes to IDLE immediately and asynchronously.
  - All outputs go to 0, except `ex_ready` = 1 while `rst_n` is high and the state is IDLE; `ex_ready` = 0 while `rst_n` is low.
  - Counters clear to 0.
  - A redirect in progress is dropped.

## Configuration
- `BR_CTRL_PERF_CNT_EN` defined:
  - `perf_br_cnt` increments on every `res_valid`.
  - `perf_mispred_cnt` increments on every `redirect_valid`.
  - Both saturate at all-ones; no wrap.
- Not defined: counter logic is absent and both ports are tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Taken branch, correctly predicted: beq, rs1=rs2=0x5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> `res_valid` at N+1 with `res_taken`=1 and `res_target`=0x120; no redirect or flush; `ex_ready` back to 1 at N+2.
- Signed vs unsigned: blt with rs1=0xFFFFFFFF, rs2=1 -> taken. Same operands with bltu -> not taken; pc=0x200, not compressed, pred_taken=1 -> `redirect_pc`=0x204 and `flush` high for 2 cycles.
- JALR with wrap and compressed flag: rs1=0xFFFFFFF0, imm=0x13, `ex_is_c`=1, pred_taken=0 -> `redirect_pc`=0x00000002; `ex_valid` held during FLUSH is not accepted until `ex_ready` returns.
- Taken with wrong target: bne, rs1=1, rs2=2, pc=0x40, imm=-8, pred_target=0x50 -> `redirect_pc`=0x38. Run with FLUSH_CYCLES=1 and 4 and check `flush` width of 1 and 4 cycles.
- Reset: assert `rst_n` low mid-FLUSH -> `flush`, `redirect_valid` and counters go to 0 at once; after release, `ex_ready`=1 and the next branch resolves normally.
- With `BR_CTRL_PERF_CNT_EN` defined, CNT_W=4: 20 mispredicts -> both counters hold 0xF. Without the macro, both counters stay 0.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Resolves one branch/JAL/JALR at a time, compares the outcome against the prediction, and issues redirect plus a FLUSH_CYCLES-wide flush.
// Latency: accept at edge N, resolution/redirect at cycle N+1. Backpressure: ex_ready low outside IDLE.
// Optional saturating perf counters under `BR_CTRL_PERF_CNT_EN`; without it both counter ports are tied to 0.
module branch_resolve_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic [31:0]      ex_rs2,
  input  logic [2:0]       ex_cmp_op,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             ex_is_c,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             res_valid,
  output logic             res_taken,
  output logic [31:0]      res_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] perf_br_cnt,
  output logic [CNT_W-1:0] perf_mispred_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  cmp_op;
    logic        is_jal;
    logic        is_jalr;
    logic        is_c;
    logic        pred_taken;
    logic [31:0] pred_target;
  } req_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  req_t       req_q;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic       accept;

  logic        eq, lt_s, lt_u, cond_taken, taken, mispred;
  logic [31:0] target, fall_thru, actual_pc;

  assign ex_ready = rst_n & (state_q == S_IDLE);
  assign accept   = ex_valid & ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (accept) begin
      req_q <= '{pc:          ex_pc,
                 imm:         ex_imm,
                 rs1:         ex_rs1,
                 rs2:         ex_rs2,
                 cmp_op:      ex_cmp_op,
                 is_jal:      ex_is_jal,
                 is_jalr:     ex_is_jalr,
                 is_c:        ex_is_c,
                 pred_taken:  ex_pred_taken,
                 pred_target: ex_pred_target};
    end
  end

  // Resolution datapath works purely from the registered request.
  always_comb begin
    eq   = (req_q.rs1 == req_q.rs2);
    lt_s = ($signed(req_q.rs1) < $signed(req_q.rs2));
    lt_u = (req_q.rs1 < req_q.rs2);
    case (req_q.cmp_op)
      3'b000:  cond_taken = eq;
      3'b001:  cond_taken = ~eq;
      3'b100:  cond_taken = lt_s;
      3'b101:  cond_taken = ~lt_s;
      3'b110:  cond_taken = lt_u;
      3'b111:  cond_taken = ~lt_u;
      default: cond_taken = 1'b0;
    endcase
    taken = req_q.is_jal | req_q.is_jalr | cond_taken;

    if (req_q.is_jalr) begin
      target = (req_q.rs1 + req_q.imm) & 32'hFFFF_FFFE;
    end else begin
      target = req_q.pc + req_q.imm;
    end
    fall_thru = req_q.pc + (req_q.is_c ? 32'd2 : 32'd4);
    actual_pc = taken ? target : fall_thru;

    mispred = (taken != req_q.pred_taken) |
              (taken & req_q.pred_taken & (target != req_q.pred_target));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (mispred) begin
          flush_cnt_d = FLUSH_LOAD;
          state_d     = (FLUSH_CYCLES <= 1) ? S_IDLE : S_FLUSH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 4'd1;
        // Counter value 1 means this is the final flush cycle.
        if (flush_cnt_q <= 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_valid      = 1'b0;
    res_taken      = 1'b0;
    res_target     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush          = 1'b0;
    case (state_q)
      S_RESOLVE: begin
        res_valid  = 1'b1;
        res_taken  = taken;
        res_target = actual_pc;
        if (mispred) begin
          redirect_valid = 1'b1;
          redirect_pc    = actual_pc;
          flush          = 1'b1;
        end
      end
      S_FLUSH: flush = 1'b1;
      default: ;
    endcase
  end

`ifdef BR_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (res_valid && (br_cnt_q != '1))       br_cnt_q  <= br_cnt_q + CNT_ONE;
      if (redirect_valid && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + CNT_ONE;
    end
  end

  assign perf_br_cnt      = br_cnt_q;
  assign perf_mispred_cnt = mis_cnt_q;
`else
  assign perf_br_cnt      = '0;
  assign perf_mispred_cnt = '0;
`endif

endmodule
